// File: rtl/multi_cycle_pkg.sv
// multi_cycle_pkg
// Shared definitions for the multi-cycle accumulator slice:
//   - state_t       : controller states (IDLE, RUN)
//   - signed_ovf()  : signed overflow of one add/subtract step, from sign bits
//   - sat_limit()   : saturation bound for a given width, sign-extended to
//                     SAT_MAX_W bits so callers can truncate to their own width
// Optional build macro used by the slice: MULTI_CYCLE_ACC_SATURATE_EN
package multi_cycle_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Widest operand width for which sat_limit() can produce a bound.
  localparam int SAT_MAX_W = 64;

  // Add overflows when both inputs share a sign and the sum's sign differs.
  // Subtract overflows when the inputs differ in sign and the difference's
  // sign differs from the accumulator's.
  function automatic logic signed_ovf(input logic acc_msb,
                                      input logic opd_msb,
                                      input logic res_msb,
                                      input logic sub);
    if (sub) begin
      return (acc_msb != opd_msb) && (res_msb != acc_msb);
    end
    return (acc_msb == opd_msb) && (res_msb != acc_msb);
  endfunction

  // negative=0 -> +2^(w-1)-1, negative=1 -> -2^(w-1), sign-extended.
  function automatic logic [SAT_MAX_W-1:0] sat_limit(input int w, input logic negative);
    logic [SAT_MAX_W-1:0] lim;
    lim = '0;
    for (int b = 0; b < SAT_MAX_W; b++) begin
      lim[b] = (b < w - 1) ? ~negative : negative;
    end
    return lim;
  endfunction

endpackage

// File: rtl/multi_cycle_addsub_step.sv
// multi_cycle_addsub_step
// One W-bit two's-complement add/subtract step of the accumulator.
// Ports:
//   acc        in  W  current accumulator value
//   operand    in  W  operand for this step
//   sub        in  1  1: acc - operand, 0: acc + operand
//   next_value out W  new accumulator value (wrapped, or clamped when saturating)
//   step_ovf   out 1  signed overflow of this step
// Build macro: MULTI_CYCLE_ACC_SATURATE_EN clamps overflowing steps to the
// signed range instead of wrapping.
module multi_cycle_addsub_step
  import multi_cycle_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] operand,
  input  logic         sub,
  output logic [W-1:0] next_value,
  output logic         step_ovf
);

  logic [W-1:0] raw_value;

  assign raw_value = sub ? (acc - operand) : (acc + operand);
  assign step_ovf  = signed_ovf(acc[W-1], operand[W-1], raw_value[W-1], sub);

`ifdef MULTI_CYCLE_ACC_SATURATE_EN
  localparam logic [W-1:0] SAT_POS = W'(sat_limit(W, 1'b0));
  localparam logic [W-1:0] SAT_NEG = W'(sat_limit(W, 1'b1));

  // On overflow the true result always has the accumulator's sign.
  assign next_value = step_ovf ? (acc[W-1] ? SAT_NEG : SAT_POS) : raw_value;
`else
  assign next_value = raw_value;
`endif

endmodule

// File: rtl/multi_cycle_accumulator.sv
// multi_cycle_accumulator
// Folds N signed W-bit operands into one result using a single shared
// add/subtract step, one operand per clock. Operand 0 loads directly; every
// later operand i is added, or subtracted when op_sub[i]=1.
// Ports:
//   clock    in  1    rising-edge clock
//   reset    in  1    asynchronous active-high reset
//   start    in  1    request, sampled only while busy=0
//   op_sub   in  N    per-operand subtract select (bit 0 ignored)
//   operands in  N*W  operand i at [i*W +: W]
//   busy     out 1    operation in progress
//   done     out 1    one-cycle pulse when result is final
//   result   out W    accumulator, held until the next accepted start
//   overflow out 1    sticky signed overflow of the current/last operation
// Build macro: MULTI_CYCLE_ACC_SATURATE_EN (saturating steps, see sub-module).
module multi_cycle_accumulator
  import multi_cycle_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   op_sub,
  input  logic [N*W-1:0] operands,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   result,
  output logic           overflow
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t           state_q,    state_d;
  logic [IDX_W-1:0] index_q,    index_d;
  logic [N*W-1:0]   ops_q,      ops_d;
  logic [N-1:0]     sub_q,      sub_d;
  logic [W-1:0]     result_q,   result_d;
  logic             overflow_q, overflow_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;

  logic [W-1:0] op_arr [N];
  logic [W-1:0] cur_op;
  logic         cur_sub;
  logic [W-1:0] step_value;
  logic         step_ovf;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign op_arr[gi] = ops_q[gi*W +: W];
    end

    // With a single operand there is no RUN phase, so the index is never used.
    if (N > 1) begin : g_sel
      assign cur_op  = op_arr[index_q];
      assign cur_sub = sub_q[index_q];
    end else begin : g_sel_single
      assign cur_op  = op_arr[0];
      assign cur_sub = 1'b0;
    end
  endgenerate

  multi_cycle_addsub_step #(
    .W(W)
  ) u_step (
    .acc       (result_q),
    .operand   (cur_op),
    .sub       (cur_sub),
    .next_value(step_value),
    .step_ovf  (step_ovf)
  );

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    ops_d      = ops_q;
    sub_d      = sub_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          // Snapshot the whole request so later input changes cannot leak in.
          ops_d      = operands;
          sub_d      = op_sub;
          result_d   = operands[W-1:0];
          overflow_d = 1'b0;
          index_d    = IDX_W'(1);
          if (N == 1) begin
            done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        result_d   = step_value;
        overflow_d = overflow_q | step_ovf;
        index_d    = index_q + 1'b1;
        if (index_q == LAST_IDX) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      index_q    <= '0;
      ops_q      <= '0;
      sub_q      <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      ops_q      <= ops_d;
      sub_q      <= sub_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_multi_cycle_accumulator.sv
// Testbench for multi_cycle_accumulator (W=8, N=4 main instance plus an N=1
// instance). Honours MULTI_CYCLE_ACC_SATURATE_EN in its reference model.
module tb_multi_cycle_accumulator;

  localparam int W = 8;
  localparam int N = 4;

  logic           clock;
  logic           reset;
  logic           start;
  logic [N-1:0]   op_sub;
  logic [N*W-1:0] operands;
  logic           busy, done, overflow;
  logic [W-1:0]   result;

  logic           start1;
  logic [0:0]     op_sub1;
  logic [W-1:0]   operands1;
  logic           busy1, done1, overflow1;
  logic [W-1:0]   result1;

  multi_cycle_accumulator #(.W(W), .N(N)) u_dut (
    .clock(clock), .reset(reset), .start(start), .op_sub(op_sub),
    .operands(operands), .busy(busy), .done(done), .result(result),
    .overflow(overflow)
  );

  multi_cycle_accumulator #(.W(W), .N(1)) u_dut1 (
    .clock(clock), .reset(reset), .start(start1), .op_sub(op_sub1),
    .operands(operands1), .busy(busy1), .done(done1), .result(result1),
    .overflow(overflow1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Number of rising edges seen so far; edge k is the edge whose count is k.
  int edge_cnt = 0;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int         k;
    logic [7:0] res;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   last_k    = -1000;
  int   next_free = 0;
  bit   in_reset  = 1'b1;
  int   n_cmp     = 0;
  int   n_bad     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: true integer arithmetic, out-of-range means overflow.
  function automatic void model(input logic [31:0] ops, input logic [3:0] sub,
                                output logic [7:0] r, output logic o);
    int acc;
    int b;
    int t;
    acc = int'($signed(ops[7:0]));
    o   = 1'b0;
    for (int i = 1; i < N; i++) begin
      b = int'($signed(ops[i*8 +: 8]));
      t = sub[i] ? acc - b : acc + b;
      if (t > 127 || t < -128) begin
        o = 1'b1;
`ifdef MULTI_CYCLE_ACC_SATURATE_EN
        t = (t > 127) ? 127 : -128;
`else
        t = ((t + 128) & 255) - 128;
`endif
      end
      acc = t;
    end
    r = acc[7:0];
  endfunction

  function automatic logic [7:0] pick_byte();
    case ($urandom_range(0, 5))
      0: return 8'h80;
      1: return 8'h7f;
      2: return 8'hff;
      3: return 8'h00;
      4: return 8'h01;
      default: return 8'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] rand_ops();
    return {pick_byte(), pick_byte(), pick_byte(), pick_byte()};
  endfunction

  // Drive one cycle of stimulus; record the expected result if accepted.
  task automatic drive(input bit st, input logic [31:0] ops, input logic [3:0] sb_in);
    exp_t e;
    @(negedge clock);
    #1;
    start    = st;
    operands = ops;
    op_sub   = sb_in;
    if (st && (edge_cnt + 1 >= next_free)) begin
      e.k = edge_cnt + 1;
      model(ops, sb_in, e.res, e.ovf);
      sb.push_back(e);
      last_k    = e.k;
      next_free = e.k + N;
      $display("issue k=%0d ops=%08h sub=%b exp_res=%02h exp_ovf=%0b",
               e.k, ops, sb_in, e.res, e.ovf);
    end
  endtask

  // Monitor: compares busy/done every cycle and the result on each done.
  always @(negedge clock) begin
    if (!in_reset) begin
      bit busy_e;
      bit done_e;
      int e;
      e      = edge_cnt;
      busy_e = (e >= last_k) && (e <= last_k + N - 2);
      done_e = (sb.size() > 0) && (sb[0].k + N - 1 == e);
      check("busy", 32'(busy), 32'(busy_e));
      check("done", 32'(done), 32'(done_e));
      if (done_e) begin
        check("result", 32'(result), 32'(sb[0].res));
        check("overflow", 32'(overflow), 32'(sb[0].ovf));
        $display("done k=%0d result=%02h overflow=%0b", sb[0].k, result, overflow);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] v;
    reset     = 1'b1;
    start     = 1'b0;
    op_sub    = '0;
    operands  = '0;
    start1    = 1'b0;
    op_sub1   = '0;
    operands1 = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_result1", 32'(result1), 32'd0);
    #1;
    reset    = 1'b0;
    in_reset = 1'b0;

    // Directed cases: {10,3,5,2} with op1 subtracted, 100+100, -128-1.
    drive(1'b1, {8'd2, 8'd5, 8'd3, 8'd10}, 4'b0010);
    repeat (N + 1) drive(1'b0, 32'h0, 4'h0);
    drive(1'b1, {8'd0, 8'd0, 8'd100, 8'd100}, 4'b0000);
    repeat (N + 1) drive(1'b0, 32'h0, 4'h0);
    drive(1'b1, {8'd0, 8'd0, 8'd1, 8'h80}, 4'b0010);
    repeat (N + 1) drive(1'b0, 32'h0, 4'h0);

    // Start repeated during RUN and operands changed after accept.
    drive(1'b1, {8'd7, 8'd6, 8'd5, 8'd4}, 4'b1000);
    drive(1'b1, {8'h7f, 8'h7f, 8'h7f, 8'h7f}, 4'b0000);
    drive(1'b0, {8'h80, 8'h80, 8'h80, 8'h80}, 4'b1110);
    repeat (N + 1) drive(1'b0, rand_ops(), 4'($urandom));

    // Start held high: back-to-back accepts in each done cycle.
    repeat (40) drive(1'b1, rand_ops(), 4'($urandom));
    repeat (N + 1) drive(1'b0, 32'h0, 4'h0);

    // Random mix of starts, ignored starts and changing inputs.
    repeat (300) drive($urandom_range(0, 9) < 6, rand_ops(), 4'($urandom));
    repeat (N + 1) drive(1'b0, 32'h0, 4'h0);

    // Reset during the second RUN cycle discards the operation.
    drive(1'b1, {8'd9, 8'd9, 8'd9, 8'h55}, 4'b0000);
    drive(1'b0, 32'h0, 4'h0);
    @(posedge clock);
    @(posedge clock);
    #2;
    in_reset = 1'b1;
    reset    = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    $display("reset mid-operation busy=%0b done=%0b result=%02h overflow=%0b",
             busy, done, result, overflow);
    sb.delete();
    last_k    = -1000;
    next_free = 0;
    @(negedge clock);
    #1;
    reset    = 1'b0;
    in_reset = 1'b0;
    repeat (N + 2) drive(1'b0, 32'h0, 4'h0);
    check("sb_drain", 32'(sb.size()), 32'd0);

    // N=1 instance: done and result at the accept edge.
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      #1;
      v         = pick_byte();
      operands1 = v;
      op_sub1   = 1'($urandom);
      start1    = 1'b1;
      @(negedge clock);
      check("n1_done", 32'(done1), 32'd1);
      check("n1_result", 32'(result1), 32'(v));
      check("n1_busy", 32'(busy1), 32'd0);
      check("n1_overflow", 32'(overflow1), 32'd0);
      $display("n1 op=%02h result=%02h done=%0b", v, result1, done1);
      #1;
      start1    = 1'b0;
      operands1 = ~v;
      @(negedge clock);
      check("n1_done_low", 32'(done1), 32'd0);
      check("n1_hold", 32'(result1), 32'(v));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_cycle_accumulator.md
Name: multi_cycle_accumulator

Overview:
Parametrised multi-cycle signed add/subtract accumulator.
- Folds N operands of W bits into one result using one shared adder/subtractor, one operand per clock.
- Each operand after the first has its own add/subtract select.
- Operand 0 loads directly into the accumulator.
- Generalises the team's fixed 4-operand, 8-bit, single-mode multi-cycle circuit.
- Adds start/busy/done handshake, operand snapshot, and a sticky signed-overflow flag.

Parameters:
W, 8, operand/result width in bits (>=2)
N, 4, number of operands (>=1)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when busy=0
op_sub  input  N  bit i=1: subtract operand i; bit 0 ignored
operands  input  N*W  operand i at bits [i*W +: W], two's complement
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when result is final
result  output  W  accumulator; holds final value until next accepted start
overflow  output  1  sticky signed overflow for current/last operation

Behaviour:
- Clock and reset: reset asynchronous, active-high; clock is clock. All state updates on the rising edge of clock.
- Reset values: busy=0, done=0, result=0, overflow=0, state=IDLE, index=0.
- States: IDLE, RUN.
- IDLE with start=1 at edge k (the accept edge):
  - snapshot operands and op_sub into internal registers; later input changes have no effect;
  - result<=operand[0]; overflow<=0; index<=1.
  - N=1: done<=1 at edge k, stay IDLE, busy stays 0.
  - N>1: busy<=1, state<=RUN.
- RUN, each edge:
  - result <= result + operand[index], or result - operand[index] when op_sub[index]=1;
  - overflow |= signed overflow of that step;
  - index <= index+1.
  - When index==N-1: done<=1, busy<=0, state<=IDLE.
- Latency: done is high for exactly the cycle after edge k+N-1.
- Throughput: a new start may be accepted in the cycle done is high, giving back-to-back operations with no idle gap.
- start while busy=1 is ignored, not queued.
- Arithmetic: W-bit two's-complement, wrap-around by default.
  - Step overflow (add): operands share sign and the sum's sign differs.
  - Step overflow (subtract): operands differ in sign and the result sign differs from the accumulator sign.
- result is stable outside the accept edge and RUN edges.
- Reset mid-operation: immediate return to reset values; no done pulse; partial result discarded.
- done is a registered pulse, never combinational from start.

Optional Feature:
MULTI_CYCLE_ACC_SATURATE_EN
- Defined: any overflowing step clamps result to +2^(W-1)-1 or -2^(W-1) according to the true sign. Later steps continue from the clamped value. overflow is still set.
- Undefined: wrap-around arithmetic as above; no extra logic is generated.

Decomposition:
- Shared package multi_cycle_pkg:
  - state enum (IDLE, RUN);
  - function for signed-overflow detection;
  - function for saturation limits for a given W.
- One natural sub-module, multi_cycle_addsub_step, parametrised by W:
  - inputs: acc, operand, sub;
  - outputs: next value, step overflow;
  - contains the saturation logic under the macro.
- The FSM, index counter and snapshot registers stay in the top.

Test Plan:
1. W=8, N=4, operands {10,3,5,2}, op_sub=4'b0010 -> done pulse 3 cycles after accept edge; result=14; overflow=0; busy high exactly 3 cycles.
2. Operands {100,100,0,0}, op_sub=0 -> result=0xC8 (-56), overflow=1. With MULTI_CYCLE_ACC_SATURATE_EN -> result=127, overflow=1.
3. Operands {-128,1,0,0}, op_sub=4'b0010 -> overflow=1; result=127 wrapped, -128 saturated.
4. Start pulsed again during RUN, and operands changed after accept -> result reflects only the snapshot; exactly one done pulse.
5. Start held high across done -> second operation accepted in the done cycle; second result correct; overflow cleared at second accept.
6. Reset asserted at the second RUN cycle -> busy, done, result, overflow all 0 immediately. N=1 build -> done at accept edge, result=operand[0].
